iter_alu: RTL and testbench

- Parametrised, registered successor to the single-cycle datapath ALU for the MIPS core.
- Keeps the existing op encodings for AND/OR/ADD/SUB/SLT. Adds unsigned SLTU plus iterative unsigned MUL and DIVU, one bit per cycle.
- Uses a start/valid handshake so the controller can stall on multi-cycle ops.
- Sits in EX stage between register-file read and write-back/HI-LO capture.

---
 rtl/iter_alu_if.sv | 26 ++
 rtl/iter_alu.sv | 162 ++++++++++++++++
 tb/tb_iter_alu.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iter_alu_if.sv
// Request/response bundle for the iterative EX-stage ALU.
// The controller drives the master side and the ALU drives the slave side.
interface iter_alu_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       ALUoperation;
   logic             ready;
   logic [WIDTH-1:0] ALUResult;
   logic [WIDTH-1:0] hi;
   logic             zero;
   logic             valid;
   logic             div_by_zero;

   modport master (
      output start, A, B, ALUoperation,
      input  ready, ALUResult, hi, zero, valid, div_by_zero
   );

   modport slave (
      input  start, A, B, ALUoperation,
      output ready, ALUResult, hi, zero, valid, div_by_zero
   );
endinterface

// File: rtl/iter_alu.sv
// Registered MIPS EX-stage ALU.
// Logic ops finish in one cycle; MUL and DIVU iterate one bit per cycle behind a start/valid handshake.
module iter_alu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic      clk,
   input  logic      rst,
   iter_alu_if.slave bus
);
   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_MUL  = 3'b011;
   localparam logic [2:0] OP_DIVU = 3'b100;
   localparam logic [2:0] OP_SLTU = 3'b101;
   localparam logic [2:0] OP_SUB  = 3'b110;
   localparam logic [2:0] OP_SLT  = 3'b111;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_ready;
   logic             r_valid;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_hi_out;
   logic             r_zero;
   logic             r_dbz;

   logic [WIDTH-1:0] w_single;
   logic             w_div0;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH-1:0] w_mul_hi;
   logic [WIDTH-1:0] w_mul_lo;
   logic [WIDTH:0]   w_div_shift;
   logic             w_div_ge;
   logic [WIDTH-1:0] w_div_hi;
   logic [WIDTH-1:0] w_div_lo;
   logic             w_last;

   always_comb begin
      w_div0   = (bus.ALUoperation == OP_DIVU) && (bus.B == '0);
      w_single = '0;
      case (bus.ALUoperation)
         OP_AND:  w_single = bus.A & bus.B;
         OP_OR:   w_single = bus.A | bus.B;
         OP_ADD:  w_single = bus.A + bus.B;
         OP_SUB:  w_single = bus.A - bus.B;
         OP_SLT:  w_single = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
         OP_SLTU: w_single = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
         OP_DIVU: w_single = '1;  // only reaches the output when the divisor is zero
         default: w_single = '0;
      endcase
   end

   // MUL: r_lo starts as the multiplier and is shifted out LSB first while the product fills in from the top.
   always_comb begin
      w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
      w_mul_hi  = w_mul_sum[WIDTH:1];
      w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
   end

   // DIVU: r_hi is the partial remainder, r_lo shifts dividend bits out and quotient bits in.
   always_comb begin
      w_div_shift = {r_hi, r_lo[WIDTH-1]};
      w_div_ge    = (w_div_shift >= {1'b0, r_a});
      w_div_hi    = w_div_ge ? (w_div_shift[WIDTH-1:0] - r_a) : w_div_shift[WIDTH-1:0];
      w_div_lo    = {r_lo[WIDTH-2:0], w_div_ge};
      w_last      = (r_cnt == LAST_STEP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_a      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_ready  <= 1'b1;
         r_valid  <= 1'b0;
         r_result <= '0;
         r_hi_out <= '0;
         r_zero   <= 1'b0;
         r_dbz    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.ALUoperation == OP_MUL) begin
                     r_a     <= bus.A;
                     r_hi    <= '0;
                     r_lo    <= bus.B;
                     r_cnt   <= '0;
                     r_ready <= 1'b0;
                     r_state <= S_MUL;
                  end else if (bus.ALUoperation == OP_DIVU && !w_div0) begin
                     r_a     <= bus.B;
                     r_hi    <= '0;
                     r_lo    <= bus.A;
                     r_cnt   <= '0;
                     r_ready <= 1'b0;
                     r_state <= S_DIV;
                  end else begin
                     r_result <= w_single;
                     r_hi_out <= w_div0 ? bus.A : '0;
                     r_zero   <= (w_single == '0);
                     r_dbz    <= w_div0;
                     r_valid  <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               r_hi  <= w_mul_hi;
               r_lo  <= w_mul_lo;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_result <= w_mul_lo;
                  r_hi_out <= w_mul_hi;
                  r_zero   <= (w_mul_lo == '0);
                  r_dbz    <= 1'b0;
                  r_valid  <= 1'b1;
                  r_ready  <= 1'b1;
                  r_cnt    <= '0;
                  r_state  <= S_IDLE;
               end
            end
            S_DIV: begin
               r_hi  <= w_div_hi;
               r_lo  <= w_div_lo;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_result <= w_div_lo;
                  r_hi_out <= w_div_hi;
                  r_zero   <= (w_div_lo == '0);
                  r_dbz    <= 1'b0;
                  r_valid  <= 1'b1;
                  r_ready  <= 1'b1;
                  r_cnt    <= '0;
                  r_state  <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.ready       = r_ready;
   assign bus.valid       = r_valid;
   assign bus.ALUResult   = r_result;
   assign bus.hi          = r_hi_out;
   assign bus.zero        = r_zero;
   assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: directed cases plus random ops against an arithmetic reference model.
// Runs a 32-bit and an 8-bit instance side by side.
module tb_iter_alu;
   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_MUL  = 3'b011;
   localparam logic [2:0] OP_DIVU = 3'b100;
   localparam logic [2:0] OP_SLTU = 3'b101;
   localparam logic [2:0] OP_SUB  = 3'b110;
   localparam logic [2:0] OP_SLT  = 3'b111;

   typedef struct packed {
      logic [63:0] res;
      logic [63:0] hi;
      logic        dbz;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec  = 0;
   int   n_fail = 0;

   iter_alu_if #(.WIDTH(32)) bus32 ();
   iter_alu_if #(.WIDTH(8))  bus8 ();

   iter_alu #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
   iter_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog");
   end

   // Reference model: plain integer arithmetic on w-bit unsigned values.
   function automatic res_t model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input int w);
      res_t        r;
      logic [63:0] m;
      logic [63:0] p;
      longint      sa;
      longint      sb;
      m  = (64'd1 << w) - 64'd1;
      sa = longint'(a);
      sb = longint'(b);
      if (a[w-1]) sa = sa - longint'(64'd1 << w);
      if (b[w-1]) sb = sb - longint'(64'd1 << w);
      r = '0;
      case (op)
         OP_AND:  r.res = a & b;
         OP_OR:   r.res = a | b;
         OP_ADD:  r.res = (a + b) & m;
         OP_SUB:  r.res = (a - b) & m;
         OP_SLT:  r.res = (sa < sb) ? 64'd1 : 64'd0;
         OP_SLTU: r.res = (a < b) ? 64'd1 : 64'd0;
         OP_MUL: begin
            p     = a * b;
            r.res = p & m;
            r.hi  = (p >> w) & m;
         end
         default: begin
            if (b == 0) begin
               r.res = m;
               r.hi  = a;
               r.dbz = 1'b1;
            end else begin
               r.res = a / b;
               r.hi  = a % b;
            end
         end
      endcase
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run32(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      res_t e;
      int   lat;
      int   exp_lat;
      e       = model(op, 64'(a), 64'(b), 32);
      exp_lat = (op == OP_MUL || (op == OP_DIVU && b != 0)) ? 33 : 1;
      check({tag, ".ready_in"}, 64'(bus32.ready), 64'd1);
      bus32.start = 1'b1;
      bus32.ALUoperation = op;
      bus32.A = a;
      bus32.B = b;
      tick();
      bus32.start = 1'b0;
      lat = 1;
      while (bus32.valid !== 1'b1 && lat < 80) begin
         tick();
         lat++;
      end
      check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
      check({tag, ".result"}, 64'(bus32.ALUResult), e.res);
      check({tag, ".hi"}, 64'(bus32.hi), e.hi);
      check({tag, ".zero"}, 64'(bus32.zero), 64'(e.res == 0));
      check({tag, ".dbz"}, 64'(bus32.div_by_zero), 64'(e.dbz));
      check({tag, ".ready_out"}, 64'(bus32.ready), 64'd1);
      $display("txn w32 %s op=%0d A=%h B=%h res=%h hi=%h dbz=%0d lat=%0d",
               tag, op, a, b, bus32.ALUResult, bus32.hi, bus32.div_by_zero, lat);
      tick();
      check({tag, ".pulse"}, 64'(bus32.valid), 64'd0);
   endtask

   task automatic run8(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      res_t e;
      int   lat;
      int   exp_lat;
      e       = model(op, 64'(a), 64'(b), 8);
      exp_lat = (op == OP_MUL || (op == OP_DIVU && b != 0)) ? 9 : 1;
      bus8.start = 1'b1;
      bus8.ALUoperation = op;
      bus8.A = a;
      bus8.B = b;
      tick();
      bus8.start = 1'b0;
      lat = 1;
      while (bus8.valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
      check({tag, ".result"}, 64'(bus8.ALUResult), e.res);
      check({tag, ".hi"}, 64'(bus8.hi), e.hi);
      check({tag, ".zero"}, 64'(bus8.zero), 64'(e.res == 0));
      check({tag, ".dbz"}, 64'(bus8.div_by_zero), 64'(e.dbz));
      $display("txn w8 %s op=%0d A=%h B=%h res=%h hi=%h dbz=%0d lat=%0d",
               tag, op, a, b, bus8.ALUResult, bus8.hi, bus8.div_by_zero, lat);
      tick();
   endtask

   initial begin
      int          lat;
      int          nvalid;
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      bus32.start = 1'b0;
      bus32.ALUoperation = '0;
      bus32.A = '0;
      bus32.B = '0;
      bus8.start = 1'b0;
      bus8.ALUoperation = '0;
      bus8.A = '0;
      bus8.B = '0;

      #12;
      check("reset.ready", 64'(bus32.ready), 64'd1);
      check("reset.valid", 64'(bus32.valid), 64'd0);
      check("reset.result", 64'(bus32.ALUResult), 64'd0);
      check("reset.hi", 64'(bus32.hi), 64'd0);
      check("reset.zero", 64'(bus32.zero), 64'd0);
      check("reset.dbz", 64'(bus32.div_by_zero), 64'd0);
      check("reset.ready8", 64'(bus8.ready), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();

      // Compare, wrap and zero-flag cases.
      run32("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1);
      run32("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1);
      run32("sub_eq", OP_SUB, 32'd5, 32'd5);
      run32("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1);
      run32("divu", OP_DIVU, 32'd100, 32'd7);
      check("divu.quot_const", 64'(bus32.ALUResult), 64'd14);
      check("divu.rem_const", 64'(bus32.hi), 64'd2);
      run32("divu_by0", OP_DIVU, 32'h1234, 32'd0);
      check("divu_by0.res_const", 64'(bus32.ALUResult), 64'hFFFF_FFFF);
      run32("add_pre", OP_ADD, 32'd3, 32'd4);

      // Reset asserted in the middle of a multiply.
      bus32.start = 1'b1;
      bus32.ALUoperation = OP_MUL;
      bus32.A = 32'hFFFF_FFFF;
      bus32.B = 32'hFFFF_FFFF;
      tick();
      bus32.start = 1'b0;
      nvalid = 0;
      repeat (8) begin
         tick();
         if (bus32.valid === 1'b1) nvalid++;
      end
      check("rstmid.busy", 64'(bus32.ready), 64'd0);
      rst = 1'b1;
      #1;
      check("rstmid.result", 64'(bus32.ALUResult), 64'd0);
      check("rstmid.hi", 64'(bus32.hi), 64'd0);
      check("rstmid.ready", 64'(bus32.ready), 64'd1);
      check("rstmid.valid", 64'(bus32.valid), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      repeat (40) begin
         tick();
         if (bus32.valid === 1'b1) nvalid++;
      end
      check("rstmid.no_valid", 64'(nvalid), 64'd0);
      check("rstmid.ready_after", 64'(bus32.ready), 64'd1);
      run32("mul_full", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("mul_full.lo_const", 64'(bus32.ALUResult), 64'd1);
      check("mul_full.hi_const", 64'(bus32.hi), 64'hFFFF_FFFE);

      // Back-to-back single-cycle ops with start held high.
      bus32.A = 32'hF0F0_F0F0;
      bus32.B = 32'h0FF0_0FF0;
      bus32.ALUoperation = OP_AND;
      bus32.start = 1'b1;
      tick();
      check("b2b.and_valid", 64'(bus32.valid), 64'd1);
      check("b2b.and", 64'(bus32.ALUResult), 64'h00F0_00F0);
      bus32.ALUoperation = OP_OR;
      tick();
      check("b2b.or_valid", 64'(bus32.valid), 64'd1);
      check("b2b.or", 64'(bus32.ALUResult), 64'hFFF0_FFF0);
      bus32.ALUoperation = OP_ADD;
      tick();
      check("b2b.add_valid", 64'(bus32.valid), 64'd1);
      check("b2b.add", 64'(bus32.ALUResult), 64'h00E1_00E0);
      bus32.start = 1'b0;
      tick();
      check("b2b.end", 64'(bus32.valid), 64'd0);

      // Start while busy: the ADD is ignored until the MUL's valid cycle, then accepted there.
      bus32.start = 1'b1;
      bus32.ALUoperation = OP_MUL;
      bus32.A = 32'h0001_2345;
      bus32.B = 32'h0000_6789;
      tick();
      bus32.start = 1'b0;
      lat = 1;
      repeat (4) begin
         tick();
         lat++;
      end
      bus32.start = 1'b1;
      bus32.ALUoperation = OP_ADD;
      bus32.A = 32'h11;
      bus32.B = 32'h22;
      while (bus32.valid !== 1'b1 && lat < 80) begin
         tick();
         lat++;
      end
      check("busy.latency", 64'(lat), 64'd33);
      check("busy.mul_lo", 64'(bus32.ALUResult), 64'(32'h0001_2345 * 32'h0000_6789));
      check("busy.mul_hi", 64'(bus32.hi), 64'd0);
      tick();
      bus32.start = 1'b0;
      check("busy.add_valid", 64'(bus32.valid), 64'd1);
      check("busy.add", 64'(bus32.ALUResult), 64'h33);
      $display("txn w32 busy mul then add res=%h", bus32.ALUResult);
      tick();

      // 8-bit instance.
      run8("w8_mul", OP_MUL, 8'hFF, 8'hFF);
      check("w8_mul.prod_const", {48'd0, bus8.hi, bus8.ALUResult}, 64'hFE01);
      run8("w8_divu", OP_DIVU, 8'hFF, 8'h10);
      run8("w8_slt", OP_SLT, 8'h80, 8'h7F);
      for (int i = 0; i < 20; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         run8("w8_rand", rop, ra[7:0], rb[7:0]);
      end

      // Random 32-bit ops, with small divisors mixed in so quotients vary.
      for (int i = 0; i < 30; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         case ($urandom_range(0, 5))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = ra;
            default: rb = $urandom;
         endcase
         run32("rand", rop, ra, rb);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
